// File: rtl/pokey_pkg.sv
// POKEY audio scheduler shared definitions: register addresses, AUDCTL bit map, prescaler defaults.
// No logic of its own; imported by the register file, prescaler and channel-pair counters.
// restart_on_ctl() decides whether an AUDCTL write must reload all channel counters.
package pokey_pkg;

    // CPU register select values; 10-15 decode to nothing.
    typedef enum logic [3:0] {
        AUDF1  = 4'd0,
        AUDC1  = 4'd1,
        AUDF2  = 4'd2,
        AUDC2  = 4'd3,
        AUDF3  = 4'd4,
        AUDC3  = 4'd5,
        AUDF4  = 4'd6,
        AUDC4  = 4'd7,
        AUDCTL = 4'd8,
        STIMER = 4'd9
    } pokey_reg_e;

    // AUDCTL bit positions.
    localparam int CLK15  = 0;
    localparam int HP2    = 1;
    localparam int HP1    = 2;
    localparam int LINK34 = 3;
    localparam int LINK12 = 4;
    localparam int FAST3  = 5;
    localparam int FAST1  = 6;
    localparam int POLY9  = 7;

    // clk179 cycles per base tick.
    localparam int DIV64_DEF = 28;
    localparam int DIV15_DEF = 114;

    // Only the linking and 1.79 MHz source bits change how counters are
    // interpreted, so only those force a reload of every counter.
    function automatic logic restart_on_ctl(input logic [7:0] old_ctl,
                                            input logic [7:0] new_ctl);
        return old_ctl[FAST1:LINK34] != new_ctl[FAST1:LINK34];
    endfunction

endpackage

// File: rtl/pokey_audio_sched_if.sv
// CPU register write bus into the POKEY audio scheduler.
// Single-cycle strobe, no handshake: every wr_en cycle is one accepted write.
// Ports: wr_en (strobe), wr_addr (register select), wr_data (write data).
interface pokey_audio_sched_if;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pokey_chan_pair.sv
// Two POKEY channel countdown counters, optionally linked as one 16-bit counter.
// Latency: tick_lo/tick_hi are registered, asserting the cycle after the underflow.
// No backpressure: counts on the enables given; restart reloads both and suppresses ticks.
// Ports: clk179/init, link, fast_lo (low channel clocked at 1.79 MHz), base_tick,
//        restart, audf_lo/audf_hi (frequency registers), tick_lo/tick_hi.
module pokey_chan_pair (
    input  logic       clk179,
    input  logic       init,
    input  logic       link,
    input  logic       fast_lo,
    input  logic       base_tick,
    input  logic       restart,
    input  logic [7:0] audf_lo,
    input  logic [7:0] audf_hi,
    output logic       tick_lo,
    output logic       tick_hi
);

    logic [8:0]  cnt_lo;
    logic [8:0]  cnt_hi;
    logic [8:0]  nxt_lo;
    logic [8:0]  nxt_hi;
    logic [16:0] nxt16;

    // The high channel is always on the base tick; only the low one can run at 1.79 MHz.
    logic src_lo;
    assign src_lo = fast_lo | base_tick;

    // The extra +3/+6 mirrors the pipeline delay of the original silicon when
    // the low channel is clocked directly from 1.79 MHz.
    logic [8:0] reload_lo;
    logic [8:0] reload_hi;
    assign reload_lo = fast_lo ? ({1'b0, audf_lo} + 9'd3) : {1'b0, audf_lo};
    assign reload_hi = {1'b0, audf_hi};

    // When linked, the high counter keeps all 9 bits (bit 8 absorbs a reload
    // carry above 0xFFFF) and the low counter contributes its bottom byte.
    logic [16:0] cnt16;
    logic [16:0] reload16;
    assign cnt16    = {cnt_hi, cnt_lo[7:0]};
    assign reload16 = {1'b0, audf_hi, audf_lo} + (fast_lo ? 17'd6 : 17'd0);

    logic uf_lo;
    logic uf_hi;
    assign uf_lo = !link && src_lo && (cnt_lo == 9'd0);
    assign uf_hi = link ? (src_lo && (cnt16 == 17'd0))
                        : (base_tick && (cnt_hi == 9'd0));

    always_comb begin
        nxt_lo = cnt_lo;
        nxt_hi = cnt_hi;
        nxt16  = cnt16;
        if (link) begin
            if (restart || uf_hi)
                nxt16 = reload16;
            else if (src_lo)
                nxt16 = cnt16 - 17'd1;
            nxt_hi = nxt16[16:8];
            nxt_lo = {1'b0, nxt16[7:0]};
        end else begin
            if (restart || uf_lo)
                nxt_lo = reload_lo;
            else if (src_lo)
                nxt_lo = cnt_lo - 9'd1;
            if (restart || uf_hi)
                nxt_hi = reload_hi;
            else if (base_tick)
                nxt_hi = cnt_hi - 9'd1;
        end
    end

    always_ff @(posedge clk179) begin
        if (init) begin
            cnt_lo  <= '0;
            cnt_hi  <= '0;
            tick_lo <= 1'b0;
            tick_hi <= 1'b0;
        end else begin
            cnt_lo  <= nxt_lo;
            cnt_hi  <= nxt_hi;
            tick_lo <= !restart && uf_lo;
            tick_hi <= !restart && uf_hi;
        end
    end

endmodule

// File: rtl/pokey_audio_sched.sv
// POKEY audio tick scheduler: register file, 64/15 kHz prescaler, four channel counters.
// Latency: writes visible next cycle; base_tick combinational from prescaler; chn_tick registered.
// No backpressure: every wr_en cycle is a write; ticks are one-cycle enables.
// Ports: clk179, init (sync active-high reset), cpu write bus, audf1-4/audc1-4/audctl,
//        base_tick, chn_tick[3:0] (bit n-1 = channel n).
module pokey_audio_sched
    import pokey_pkg::*;
#(
    parameter int DIV64 = DIV64_DEF,
    parameter int DIV15 = DIV15_DEF
) (
    input  logic                  clk179,
    input  logic                  init,
    pokey_audio_sched_if.slave    cpu,
    output logic [7:0]            audf1,
    output logic [7:0]            audf2,
    output logic [7:0]            audf3,
    output logic [7:0]            audf4,
    output logic [7:0]            audc1,
    output logic [7:0]            audc2,
    output logic [7:0]            audc3,
    output logic [7:0]            audc4,
    output logic [7:0]            audctl,
    output logic                  base_tick,
    output logic [3:0]            chn_tick
);

    localparam int DMAX = (DIV15 > DIV64) ? DIV15 : DIV64;
    localparam int PW   = $clog2(DMAX);

    // Reload request, one cycle after a STIMER write or a relevant AUDCTL change.
    logic restart;

    always_ff @(posedge clk179) begin
        if (init) begin
            audf1   <= '0;
            audf2   <= '0;
            audf3   <= '0;
            audf4   <= '0;
            audc1   <= '0;
            audc2   <= '0;
            audc3   <= '0;
            audc4   <= '0;
            audctl  <= '0;
            restart <= 1'b0;
        end else begin
            restart <= 1'b0;
            if (cpu.wr_en) begin
                case (cpu.wr_addr)
                    AUDF1:  audf1 <= cpu.wr_data;
                    AUDC1:  audc1 <= cpu.wr_data;
                    AUDF2:  audf2 <= cpu.wr_data;
                    AUDC2:  audc2 <= cpu.wr_data;
                    AUDF3:  audf3 <= cpu.wr_data;
                    AUDC3:  audc3 <= cpu.wr_data;
                    AUDF4:  audf4 <= cpu.wr_data;
                    AUDC4:  audc4 <= cpu.wr_data;
                    AUDCTL: begin
                        audctl  <= cpu.wr_data;
                        restart <= restart_on_ctl(audctl, cpu.wr_data);
                    end
                    STIMER: restart <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Prescaler. Switching to the shorter divider can leave pre past the new
    // terminal value; the >= compare wraps it silently instead of counting
    // all the way round the register width.
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_last;
    assign pre_last  = audctl[CLK15] ? PW'(DIV15 - 1) : PW'(DIV64 - 1);
    assign base_tick = (pre == pre_last);

    always_ff @(posedge clk179) begin
        if (init)
            pre <= '0;
        else if (pre >= pre_last)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    logic tick1, tick2, tick3, tick4;

    pokey_chan_pair u_pair12 (
        .clk179    (clk179),
        .init      (init),
        .link      (audctl[LINK12]),
        .fast_lo   (audctl[FAST1]),
        .base_tick (base_tick),
        .restart   (restart),
        .audf_lo   (audf1),
        .audf_hi   (audf2),
        .tick_lo   (tick1),
        .tick_hi   (tick2)
    );

    pokey_chan_pair u_pair34 (
        .clk179    (clk179),
        .init      (init),
        .link      (audctl[LINK34]),
        .fast_lo   (audctl[FAST3]),
        .base_tick (base_tick),
        .restart   (restart),
        .audf_lo   (audf3),
        .audf_hi   (audf4),
        .tick_lo   (tick3),
        .tick_hi   (tick4)
    );

    assign chn_tick = {tick4, tick3, tick2, tick1};

endmodule

// File: tb/tb_pokey_audio_sched.sv
// Directed bench for pokey_audio_sched: register-write table plus tick-timing sequences.
// Inputs are driven and outputs sampled on the falling edge of clk179.
// All waits on DUT events are bounded by cycle budgets.
module tb_pokey_audio_sched;

    logic       clk179 = 1'b0;
    logic       init   = 1'b1;
    logic [7:0] audf1, audf2, audf3, audf4;
    logic [7:0] audc1, audc2, audc3, audc4;
    logic [7:0] audctl;
    logic       base_tick;
    logic [3:0] chn_tick;

    pokey_audio_sched_if cpu_if ();

    pokey_audio_sched #(.DIV64(28), .DIV15(114)) dut (
        .clk179    (clk179),
        .init      (init),
        .cpu       (cpu_if),
        .audf1     (audf1),
        .audf2     (audf2),
        .audf3     (audf3),
        .audf4     (audf4),
        .audc1     (audc1),
        .audc2     (audc2),
        .audc3     (audc3),
        .audc4     (audc4),
        .audctl    (audctl),
        .base_tick (base_tick),
        .chn_tick  (chn_tick)
    );

    always #5 clk179 = ~clk179;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         idx;   // 0-3 audf1-4, 4-7 audc1-4, 8 audctl
        logic [7:0] exp;
    } wvec_t;

    wvec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_reg(input int idx);
        case (idx)
            0: return audf1;
            1: return audf2;
            2: return audf3;
            3: return audf4;
            4: return audc1;
            5: return audc2;
            6: return audc3;
            7: return audc4;
            default: return audctl;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the write was sampled.
    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        cpu_if.wr_en   = 1'b1;
        cpu_if.wr_addr = a;
        cpu_if.wr_data = d;
        @(posedge clk179);
        @(negedge clk179);
        cpu_if.wr_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk179);
            @(negedge clk179);
        end
    endtask

    // Returns at the falling edge after the last init-high rising edge, init low.
    task automatic do_reset();
        init = 1'b1;
        @(posedge clk179);
        @(negedge clk179);
        init = 1'b0;
    endtask

    // Counts rising edges until the selected signal (0-3 chn_tick bit, 4 base_tick)
    // is seen high; also reports whether any chn_tick bit in watch was ever seen.
    task automatic wait_sig(input int b, input int max_cyc, input logic [3:0] watch,
                            output int n, output bit watch_seen);
        logic [4:0] s;
        bit found;
        found = 1'b0;
        watch_seen = 1'b0;
        n = 0;
        while (!found && n < max_cyc) begin
            @(posedge clk179);
            n++;
            @(negedge clk179);
            s = {base_tick, chn_tick};
            if (s[b]) found = 1'b1;
            if ((chn_tick & watch) != 4'd0) watch_seen = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for signal %0d: got none in %0d cycles, expected one", b, max_cyc);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  n;
        bit  seen;

        vecs[0]  = '{4'd0,  8'h11, 0, 8'h11};
        vecs[1]  = '{4'd1,  8'h22, 4, 8'h22};
        vecs[2]  = '{4'd2,  8'h33, 1, 8'h33};
        vecs[3]  = '{4'd3,  8'h44, 5, 8'h44};
        vecs[4]  = '{4'd4,  8'h55, 2, 8'h55};
        vecs[5]  = '{4'd5,  8'h66, 6, 8'h66};
        vecs[6]  = '{4'd6,  8'h77, 3, 8'h77};
        vecs[7]  = '{4'd7,  8'h88, 7, 8'h88};
        vecs[8]  = '{4'd8,  8'hA5, 8, 8'hA5};
        vecs[9]  = '{4'd10, 8'hFF, 0, 8'h11};   // ignored address
        vecs[10] = '{4'd15, 8'h00, 8, 8'hA5};   // ignored address
        vecs[11] = '{4'd12, 8'hEE, 7, 8'h88};   // ignored address
        vecs[12] = '{4'd0,  8'h3C, 0, 8'h3C};

        cpu_if.wr_en   = 1'b0;
        cpu_if.wr_addr = 4'd0;
        cpu_if.wr_data = 8'd0;
        @(negedge clk179);
        do_reset();

        // Reset state
        for (int i = 0; i < 9; i++) check($sformatf("reset_reg%0d", i), get_reg(i), 0);
        check("reset_base_tick", base_tick, 0);
        check("reset_chn_tick", chn_tick, 0);

        // Register write table
        for (int i = 0; i < 13; i++) begin
            do_write(vecs[i].addr, vecs[i].data);
            check($sformatf("wr_vec%0d", i), get_reg(vecs[i].idx), vecs[i].exp);
        end

        // Defaults: first base tick 27 edges after the reset edge, then every 28.
        do_reset();
        wait_sig(4, 100, 4'd0, n, seen);
        check("dflt_first_base", n, 27);
        wait_sig(4, 100, 4'd0, n, seen);
        check("dflt_base_period", n, 28);
        wait_sig(0, 100, 4'd0, n, seen);
        check("dflt_tick_delay", n, 1);
        check("dflt_tick_all", chn_tick, 4'hF);
        cycles(1);
        check("dflt_tick_pulse", chn_tick, 0);

        // Channel 1 at 1.79 MHz, unlinked: 21 edges after STIMER, then every 20.
        do_reset();
        do_write(4'd8, 8'h40);
        do_write(4'd0, 8'h10);
        do_write(4'd9, 8'h00);
        wait_sig(0, 200, 4'd0, n, seen);
        check("fast1_first", n, 21);
        wait_sig(0, 200, 4'd0, n, seen);
        check("fast1_period", n, 20);
        cycles(1);
        check("fast1_pulse", chn_tick[0], 0);

        // Pair 1+2 linked at 1.79 MHz: 0x1234+7 = 4667 cycle period, ch1 silent.
        do_reset();
        do_write(4'd8, 8'h50);
        do_write(4'd0, 8'h34);
        do_write(4'd2, 8'h12);
        do_write(4'd9, 8'h00);
        wait_sig(1, 6000, 4'b0001, n, seen);
        check("link12_first", n, 4668);
        check("link12_lo_quiet_a", seen, 0);
        wait_sig(1, 6000, 4'b0001, n, seen);
        check("link12_period", n, 4667);
        check("link12_lo_quiet_b", seen, 0);

        // 15 kHz base: ch3 with AUDF3=2 ticks every 3*114 cycles.
        do_reset();
        do_write(4'd8, 8'h01);
        do_write(4'd4, 8'h02);
        wait_sig(2, 1000, 4'd0, n, seen);
        wait_sig(2, 1000, 4'd0, n, seen);
        check("clk15_ch3_period_a", n, 342);
        wait_sig(2, 1000, 4'd0, n, seen);
        check("clk15_ch3_period_b", n, 342);
        wait_sig(4, 300, 4'd0, n, seen);
        wait_sig(4, 300, 4'd0, n, seen);
        check("clk15_base_period", n, 114);

        // Mid-count AUDF4 change: current period keeps 6 base ticks, next is 10.
        do_reset();
        do_write(4'd6, 8'h05);
        wait_sig(3, 500, 4'd0, n, seen);
        wait_sig(3, 500, 4'd0, n, seen);
        check("mid_old_period", n, 168);
        cycles(50);
        do_write(4'd6, 8'h09);
        check("mid_audf4_visible", audf4, 8'h09);
        wait_sig(3, 500, 4'd0, n, seen);
        check("mid_current_period", 51 + n, 168);
        wait_sig(3, 500, 4'd0, n, seen);
        check("mid_new_period", n, 280);

        // init mid-operation, coinciding with a write that must be discarded.
        do_reset();
        do_write(4'd8, 8'h60);
        do_write(4'd0, 8'h01);
        do_write(4'd1, 8'h5A);
        do_write(4'd6, 8'h03);
        cycles(37);
        init           = 1'b1;
        cpu_if.wr_en   = 1'b1;
        cpu_if.wr_addr = 4'd0;
        cpu_if.wr_data = 8'hAB;
        @(posedge clk179);
        @(negedge clk179);
        init         = 1'b0;
        cpu_if.wr_en = 1'b0;
        check("rst_mid_audf1", audf1, 0);
        check("rst_mid_audc1", audc1, 0);
        check("rst_mid_audf4", audf4, 0);
        check("rst_mid_audctl", audctl, 0);
        check("rst_mid_base", base_tick, 0);
        check("rst_mid_chn", chn_tick, 0);
        wait_sig(4, 100, 4'd0, n, seen);
        check("rst_mid_first_base", n, 27);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
